// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the two-requester RAM arbiter.
// Optional feature macro: RAM_ARBITER_INIT_EN (power-up fill of the RAM).
package ram_arbiter_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 8;
  localparam int INIT_WORDS = 1024;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  // Fill pattern written during INIT: (2*index) mod 256.
  function automatic logic [7:0] init_word(input logic [6:0] idx);
    init_word = {idx, 1'b0};
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins; on a tie the
// requester that was not granted last time wins.
module rr_arb2 (
  input  logic       i_valid0,
  input  logic       i_valid1,
  input  logic       i_last_grant,
  output logic [1:0] o_grant
);

  // One-hot grant selection.
  always_comb begin
    o_grant = 2'b00;
    if (i_valid0 && i_valid1) begin
      if (i_last_grant) begin
        o_grant = 2'b01;
      end else begin
        o_grant = 2'b10;
      end
    end else if (i_valid0) begin
      o_grant = 2'b01;
    end else if (i_valid1) begin
      o_grant = 2'b10;
    end else begin
      o_grant = 2'b00;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-requester arbiter in front of a single-port RAM. Each command takes
// three cycles: accept (IDLE), RAM access (ACCESS), completion pulse (RESP).
// Optional feature macro: RAM_ARBITER_INIT_EN -- when defined, reset enters
// INIT and fills every word with (2*addr) mod 256 before accepting commands.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_write,
  output logic              ram_select,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              init_done
);

`ifdef RAM_ARBITER_INIT_EN
  localparam state_t            LP_RST_STATE = ST_INIT;
  localparam logic [ADDR_W-1:0] LP_LAST_WORD = ADDR_W'(INIT_WORDS - 1);
  logic [ADDR_W-1:0] r_cnt;
`else
  localparam state_t LP_RST_STATE = ST_IDLE;
`endif

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_init_done;
  logic              r_last_grant;
  logic              r_cmd_id;
  logic              r_cmd_write;
  logic [ADDR_W-1:0] r_cmd_addr;
  logic [DATA_W-1:0] r_cmd_wdata;
  logic              r_rsp_valid0;
  logic              r_rsp_valid1;
  logic [DATA_W-1:0] r_rsp_rdata0;
  logic [DATA_W-1:0] r_rsp_rdata1;
  logic [1:0]        w_grant;
  logic              w_accept;

  rr_arb2 u_rr_arb2 (
    .i_valid0     (req0_valid),
    .i_valid1     (req1_valid),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant)
  );

  assign w_accept   = (r_state == ST_IDLE) && r_init_done && (req0_valid || req1_valid);
  assign req0_ready = w_accept && w_grant[0];
  assign req1_ready = w_accept && w_grant[1];
  assign rsp0_valid = r_rsp_valid0;
  assign rsp1_valid = r_rsp_valid1;
  assign rsp0_rdata = r_rsp_rdata0;
  assign rsp1_rdata = r_rsp_rdata1;
  assign init_done  = r_init_done;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= LP_RST_STATE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INIT: begin
`ifdef RAM_ARBITER_INIT_EN
        if (r_cnt == LP_LAST_WORD) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_INIT;
        end
`else
        w_state_nxt = ST_IDLE;
`endif
      end
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_ACCESS;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ACCESS: w_state_nxt = ST_RESP;
      ST_RESP:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = LP_RST_STATE;
    endcase
  end

  // RAM port drive; strobes are only active in INIT and ACCESS.
  always_comb begin
    ram_select = 1'b0;
    ram_write  = 1'b0;
    ram_addr   = '0;
    ram_din    = '0;
    case (r_state)
      ST_INIT: begin
`ifdef RAM_ARBITER_INIT_EN
        // Gated by rst_n so no fill write happens while reset is held.
        ram_select = rst_n;
        ram_write  = rst_n;
        ram_addr   = r_cnt;
        ram_din    = DATA_W'(init_word(r_cnt[6:0]));
`endif
      end
      ST_ACCESS: begin
        ram_select = 1'b1;
        ram_write  = r_cmd_write;
        ram_addr   = r_cmd_addr;
        ram_din    = r_cmd_wdata;
      end
      default: begin
        ram_select = 1'b0;
        ram_write  = 1'b0;
      end
    endcase
  end

`ifdef RAM_ARBITER_INIT_EN
  // Fill counter and init_done flag, raised on the edge that leaves INIT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_init_done <= 1'b0;
    end else if (r_state == ST_INIT) begin
      r_cnt       <= r_cnt + 1'b1;
      r_init_done <= (r_cnt == LP_LAST_WORD);
    end else begin
      r_cnt       <= r_cnt;
      r_init_done <= r_init_done;
    end
  end
`else
  // Without a fill phase the RAM is usable one cycle after reset release.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_init_done <= 1'b0;
    end else begin
      r_init_done <= 1'b1;
    end
  end
`endif

  // Command latch on accept, read-data capture at end of ACCESS, response pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
      r_cmd_id     <= 1'b0;
      r_cmd_write  <= 1'b0;
      r_cmd_addr   <= '0;
      r_cmd_wdata  <= '0;
      r_rsp_valid0 <= 1'b0;
      r_rsp_valid1 <= 1'b0;
      r_rsp_rdata0 <= '0;
      r_rsp_rdata1 <= '0;
    end else begin
      if (w_accept) begin
        r_last_grant <= w_grant[1];
        r_cmd_id     <= w_grant[1];
        r_cmd_write  <= w_grant[1] ? req1_write : req0_write;
        r_cmd_addr   <= w_grant[1] ? req1_addr  : req0_addr;
        r_cmd_wdata  <= w_grant[1] ? req1_wdata : req0_wdata;
      end
      r_rsp_valid0 <= (r_state == ST_ACCESS) && !r_cmd_id;
      r_rsp_valid1 <= (r_state == ST_ACCESS) &&  r_cmd_id;
      if (r_state == ST_ACCESS) begin
        r_rsp_rdata0 <= (!r_cmd_id && !r_cmd_write) ? ram_dout : '0;
        r_rsp_rdata1 <= ( r_cmd_id && !r_cmd_write) ? ram_dout : '0;
      end else begin
        r_rsp_rdata0 <= '0;
        r_rsp_rdata1 <= '0;
      end
    end
  end

endmodule
